// File: rtl/lsu_pkg.sv
// Shared types and helpers for the byte-serial load/store sequencer.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Access size encodings (funct3[1:0])
    localparam logic [1:0] BYTE = 2'b00;
    localparam logic [1:0] HALF = 2'b01;
    localparam logic [1:0] WORD = 2'b10;

    // RISC-V load/store funct3 encodings
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    // Stores have no unsigned variant; loads allow the two unsigned forms.
    function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        if (is_store) begin
            ok = (f3 == SB) || (f3 == SH) || (f3 == SW);
        end else begin
            ok = (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
        end
        return ok;
    endfunction

    // Halves need even addresses, words need 4-byte alignment.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == HALF) && addr_lo[0]) || ((size == WORD) && (addr_lo != 2'b00));
    endfunction

    // Byte index of the final ACCESS cycle for a given size.
    function automatic logic [1:0] last_index(input logic [1:0] size);
        logic [1:0] idx;
        case (size)
            BYTE:    idx = 2'd0;
            HALF:    idx = 2'd1;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/lsu_byte_sequencer_load_extender.sv
// Sign/zero extension of an assembled little-endian load value.
module load_extender
    import lsu_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    // Replicate the top loaded bit for signed loads, zero-fill otherwise.
    always_comb begin
        result = raw;
        case (size)
            BYTE:    result = {{24{~is_unsigned & raw[7]}},  raw[7:0]};
            HALF:    result = {{16{~is_unsigned & raw[15]}}, raw[15:0]};
            default: result = raw;
        endcase
    end

endmodule

// File: rtl/lsu_byte_sequencer.sv
// Sequences word/half/byte loads and stores onto a byte-wide memory,
// one byte per cycle, little-endian.
module lsu_byte_sequencer
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] address,
    output logic [31:0]       write_data,
    input  logic [31:0]       read_data
);

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] base_reg;
    logic [2:0]        funct3_reg;
    logic              store_reg;
    logic [31:0]       wdata_reg;
    logic [1:0]        k_reg;
    logic [31:0]       raw_reg;
    logic [31:0]       rdata_reg;
    logic              err_reg;

    logic              req_bad;
    logic              last_byte;
    logic [31:0]       raw_merged;
    logic [31:0]       ext_result;
    logic [7:0]        wdata_lanes [4];
    logic              unused_read_hi;

    assign req_bad   = !funct3_legal(req_store, req_funct3) ||
                       misaligned(req_funct3[1:0], req_addr[1:0]);
    assign last_byte = (k_reg == last_index(funct3_reg[1:0]));

    // Only the low byte of the memory read bus carries data.
    assign unused_read_hi = ^read_data[31:8];

    // Per-lane views: the incoming byte lands in lane k; store lanes are muxed by k.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign raw_merged[8*gi +: 8] = (k_reg == 2'(gi)) ? read_data[7:0] : raw_reg[8*gi +: 8];
            assign wdata_lanes[gi]       = wdata_reg[8*gi +: 8];
        end
    endgenerate

    // Extension sees the word including the byte arriving this cycle, so
    // rdata can be written on the same edge that enters DONE.
    load_extender u_ext (
        .raw         (raw_merged),
        .size        (funct3_reg[1:0]),
        .is_unsigned (funct3_reg[2]),
        .result      (ext_result)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: bad requests skip straight to DONE; legal ones spend N cycles in ACCESS.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    state_next = req_bad ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                if (last_byte) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request capture, byte counter, load assembly and result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_reg   <= '0;
            funct3_reg <= '0;
            store_reg  <= 1'b0;
            wdata_reg  <= '0;
            k_reg      <= '0;
            raw_reg    <= '0;
            rdata_reg  <= '0;
            err_reg    <= 1'b0;
        end else if (state_reg == IDLE && req_valid) begin
            base_reg   <= req_addr;
            funct3_reg <= req_funct3;
            store_reg  <= req_store;
            wdata_reg  <= req_wdata;
            k_reg      <= '0;
            raw_reg    <= '0;
            err_reg    <= req_bad;
        end else if (state_reg == ACCESS) begin
            if (!store_reg) begin
                raw_reg <= raw_merged;
            end
            if (last_byte) begin
                k_reg <= '0;
                if (!store_reg) begin
                    rdata_reg <= ext_result;
                end
            end else begin
                k_reg <= k_reg + 2'd1;
            end
        end
    end

    // Outputs decoded from state; memory bus is idle (all zero) outside ACCESS.
    always_comb begin
        req_ready  = (state_reg == IDLE);
        done       = (state_reg == DONE);
        err        = (state_reg == DONE) && err_reg;
        rdata      = rdata_reg;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        address    = '0;
        write_data = '0;
        if (state_reg == ACCESS) begin
            MemRead  = !store_reg;
            MemWrite = store_reg;
            address  = base_reg + ADDR_W'(k_reg);
            if (store_reg) begin
                write_data = {24'b0, wdata_lanes[k_reg]};
            end
        end
    end

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Self-checking bench for lsu_byte_sequencer with a byte-memory model and
// a scoreboard of expected memory writes and completions.
module tb_lsu_byte_sequencer;

    localparam logic [2:0] F_LB = 3'b000, F_LH = 3'b001, F_LW = 3'b010;
    localparam logic [2:0] F_LBU = 3'b100, F_LHU = 3'b101;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;

    always #5 clk = ~clk;

    lsu_byte_sequencer #(.ADDR_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .done       (done),
        .err        (err),
        .rdata      (rdata),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data)
    );

    // Byte memory model: combinational read, write on posedge.
    logic [7:0] mem [0:255];
    assign read_data = {24'b0, mem[address[7:0]]};
    always @(posedge clk) begin
        if (MemWrite) mem[address[7:0]] <= write_data[7:0];
    end

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;
    typedef struct {
        bit          e;
        logic [31:0] rd;
        int          acc;
        int          lat;
    } dn_t;

    wr_t exp_wr[$];
    dn_t exp_dn[$];
    int  acc_log[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] model_rdata = 32'h0;
    bit          prev_done = 1'b0;
    wr_t         mw;
    dn_t         md;

    // Reference model evaluated when a request is accepted.
    task automatic model_accept(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        bit          legal;
        bit          mis;
        bit          e;
        int          n;
        logic [31:0] v;
        logic [31:0] ba;
        dn_t         d;
        legal = st ? (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010)
                   : (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b100 || f3 == 3'b101);
        mis   = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
        e     = !legal || mis;
        n     = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        if (!e && st) begin
            for (int k = 0; k < n; k++) begin
                wr_t w;
                w.addr = a + 32'(k);
                w.data = wd[8*k +: 8];
                exp_wr.push_back(w);
            end
        end
        if (!e && !st) begin
            v = 32'h0;
            for (int k = 0; k < n; k++) begin
                ba = a + 32'(k);
                v[8*k +: 8] = mem[ba[7:0]];
            end
            if (!f3[2] && v[8*n-1]) begin
                for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
            end
            model_rdata = v;
        end
        d.e   = e;
        d.rd  = model_rdata;
        d.acc = cyc;
        d.lat = e ? 1 : n + 1;
        exp_dn.push_back(d);
        acc_log.push_back(cyc);
    endtask

    // Cycle counter and acceptance detection.
    always @(posedge clk) begin
        if (!reset && req_valid && req_ready) model_accept(req_store, req_funct3, req_addr, req_wdata);
        cyc <= cyc + 1;
    end

    // Output monitor: compares bus activity and completions against the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            prev_done = 1'b0;
        end else begin
            if (MemRead) rd_cnt++;
            if (MemRead && MemWrite) begin
                checks++; errors++;
                $display("FAIL strobe_overlap: MemRead=%0b MemWrite=%0b, required not both", MemRead, MemWrite);
            end
            if (!MemRead && !MemWrite) begin
                checks++;
                if (address !== 32'h0 || write_data !== 32'h0) begin
                    errors++;
                    $display("FAIL idle_bus: address=%h write_data=%h, required 0/0", address, write_data);
                end
            end
            if (MemWrite) begin
                wr_cnt++;
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: address=%h data=%h, required no write", address, write_data);
                end else begin
                    mw = exp_wr.pop_front();
                    if (address !== mw.addr || write_data !== {24'b0, mw.data}) begin
                        errors++;
                        $display("FAIL write: got %h<=%h, required %h<=%h", address, write_data, mw.addr, {24'b0, mw.data});
                    end
                end
            end
            if (done) begin
                done_cnt++;
                checks++;
                if (exp_dn.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: err=%0b rdata=%h", err, rdata);
                end else begin
                    md = exp_dn.pop_front();
                    if (err !== md.e || rdata !== md.rd || (cyc - md.acc) != md.lat) begin
                        errors++;
                        $display("FAIL done: err=%0b rdata=%h latency=%0d, required err=%0b rdata=%h latency=%0d",
                                 err, rdata, cyc - md.acc, md.e, md.rd, md.lat);
                    end
                end
                $display("txn done: err=%0b rdata=%h", err, rdata);
            end
            if (prev_done && done) begin
                checks++; errors++;
                $display("FAIL done_width: done high 2 cycles, required 1");
            end
            prev_done = done;
        end
    end

    // Drive one request; returns #1 after acceptance, optionally waits for done.
    task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit wait_done);
        int target;
        bit ok;
        target = done_cnt + 1;
        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        #1;
        req_valid = 1'b0;
        req_store = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout: req_ready=%0b, required 1 within 20 cycles", req_ready);
        end
        if (wait_done && ok) begin
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk); #1;
                if (done_cnt >= target) begin ok = 1'b1; break; end
            end
            if (!ok) begin
                checks++; errors++;
                $display("FAIL done_timeout: done_cnt=%0d, required %0d", done_cnt, target);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({done, err, MemRead, MemWrite} !== 4'b0 || address !== 32'h0 || write_data !== 32'h0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: done=%0b err=%0b rd=%0b wr=%0b addr=%h wd=%h rdata=%h, required all 0",
                     done, err, MemRead, MemWrite, address, write_data, rdata);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: req_ready=%0b, required 1", req_ready);
        end
    endtask

    task automatic test_store_word();
        int wc;
        wc = wr_cnt;
        issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1);
        checks++;
        if (wr_cnt - wc != 4 || mem[8'h10] !== 8'hEF || mem[8'h11] !== 8'hBE || mem[8'h12] !== 8'hAD || mem[8'h13] !== 8'hDE) begin
            errors++;
            $display("FAIL store_word: writes=%0d mem=%h %h %h %h, required 4 EF BE AD DE",
                     wr_cnt - wc, mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s  [5] = '{F_LW, F_LH, F_LHU, F_LB, F_LBU};
        logic [31:0] adrs [5] = '{32'h10, 32'h12, 32'h12, 32'h11, 32'h11};
        logic [31:0] expv [5] = '{32'hDEADBEEF, 32'hFFFFDEAD, 32'h0000DEAD, 32'hFFFFFFBE, 32'h000000BE};
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, f3s[i], adrs[i], 32'h0, 1'b1);
            checks++;
            if (rdata !== expv[i]) begin
                errors++;
                $display("FAIL load_%0d: rdata=%h, required %h", i, rdata, expv[i]);
            end
        end
    endtask

    task automatic test_sub_word_stores();
        issue(1'b1, 3'b001, 32'h20, 32'hABCD1234, 1'b1);
        issue(1'b1, 3'b000, 32'h22, 32'h55667799, 1'b1);
        issue(1'b0, F_LW, 32'h20, 32'h0, 1'b1);
        checks++;
        if (rdata !== 32'h00991234) begin
            errors++;
            $display("FAIL sub_word_stores: rdata=%h, required 00991234", rdata);
        end
        issue(1'b0, F_LHU, 32'h22, 32'h0, 1'b1);
        checks++;
        if (rdata !== 32'h00000099) begin
            errors++;
            $display("FAIL lhu_after_sb: rdata=%h, required 00000099", rdata);
        end
    endtask

    task automatic test_errors();
        bit          sts  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [2:0]  f3s  [5] = '{F_LW, 3'b001, 3'b100, 3'b011, F_LH};
        logic [31:0] adrs [5] = '{32'h21, 32'h03, 32'h30, 32'h30, 32'h31};
        int rc;
        int wc;
        for (int i = 0; i < 5; i++) begin
            rc = rd_cnt;
            wc = wr_cnt;
            issue(sts[i], f3s[i], adrs[i], 32'hCAFEF00D, 1'b1);
            checks++;
            if (rd_cnt != rc || wr_cnt != wc || rdata !== 32'h00000099) begin
                errors++;
                $display("FAIL error_%0d: reads=%0d writes=%0d rdata=%h, required 0 0 00000099",
                         i, rd_cnt - rc, wr_cnt - wc, rdata);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        int dc;
        dc = done_cnt;
        issue(1'b1, 3'b010, 32'h40, 32'h11223344, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (exp_wr.size() != 3) begin
            errors++;
            $display("FAIL abort_pending: outstanding writes=%0d, required 3", exp_wr.size());
        end
        exp_wr.delete();
        exp_dn.delete();
        model_rdata = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || rdata !== 32'h0 || mem[8'h40] !== 8'h44 || mem[8'h41] !== 8'h00 || done_cnt != dc) begin
            errors++;
            $display("FAIL reset_mid_access: ready=%0b rdata=%h mem40=%h mem41=%h dones=%0d, required 1 0 44 00 0",
                     req_ready, rdata, mem[8'h40], mem[8'h41], done_cnt - dc);
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        int dc;
        bit ok;
        n0 = acc_log.size();
        dc = done_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = F_LW; req_addr = 32'h10; req_wdata = 32'h0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (acc_log.size() >= n0 + 3) begin ok = 1'b1; break; end
        end
        req_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done_cnt >= dc + 3) break;
            @(negedge clk); #1;
        end
        checks++;
        if (!ok || done_cnt < dc + 3) begin
            errors++;
            $display("FAIL b2b_progress: accepts=%0d dones=%0d, required 3 3", acc_log.size() - n0, done_cnt - dc);
        end else begin
            checks++;
            if (acc_log[n0+1] - acc_log[n0] != 6 || acc_log[n0+2] - acc_log[n0+1] != 6) begin
                errors++;
                $display("FAIL b2b_spacing: gaps=%0d,%0d, required 6,6",
                         acc_log[n0+1] - acc_log[n0], acc_log[n0+2] - acc_log[n0+1]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_store_word();
        test_loads();
        test_sub_word_stores();
        test_errors();
        test_reset_mid_access();
        test_back_to_back();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_wr.size() != 0 || exp_dn.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: writes=%0d dones=%0d, required 0 0", exp_wr.size(), exp_dn.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
